// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and architectural constants.
package cpu_pkg;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam logic [3:0]  OP_HLT       = 4'hF;
  localparam logic [15:0] NOP_INSTR    = 16'h0000;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/pc_reg.sv
// Program counter register: async active-low reset, load-enabled update.
module pc_reg #(
  parameter int            W       = 16,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   q_o <= RST_VAL;
    else if (ld_i) q_o <= d_i;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem over req/ready, feeds the F/D flops,
// and handles stalls, decode-resolved redirects and HLT.
module fetch_stage import cpu_pkg::*; #(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC),
  parameter logic [3:0]        HALT_OPCODE = OP_HLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instruction_out,
  output logic [ADDR_W-1:0] oldPC_out,
  output logic [ADDR_W-1:0] newPC_out,
  output logic              fd_wen,
  output logic              fd_valid,
  output logic              halted
);
  fetch_state_t      state_q, state_d;
  logic              pend_redir_q, pend_redir_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              pc_ld;
  logic              req, hlt, wen, vld;
  logic              is_hlt, redir_now;

  pc_reg #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_pc (
    .clk_i  (clk),
    .rst_ni (rst),
    .ld_i   (pc_ld),
    .d_i    (pc_d),
    .q_o    (pc_q)
  );

  assign pc_inc    = pc_q + ADDR_W'(2);
  assign is_hlt    = (imem_rdata[15:12] == HALT_OPCODE);
  // A redirect that arrived during a miss is applied once that miss returns.
  assign redir_now = (state_q == WAIT) && pend_redir_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      pend_redir_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_redir_q  <= pend_redir_d;
      pend_target_q <= pend_target_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_redir_d  = pend_redir_q;
    pend_target_d = pend_target_q;
    pc_ld         = 1'b0;
    pc_d          = pc_inc;
    case (state_q)
      RUN, WAIT: begin
        if (branch_taken) begin
          // In WAIT the request must drain first, unless it completes right now.
          if (state_q == RUN || imem_ready) begin
            pc_ld        = 1'b1;
            pc_d         = branch_target;
            state_d      = RUN;
            pend_redir_d = 1'b0;
          end else begin
            pend_redir_d  = 1'b1;
            pend_target_d = branch_target;
          end
        end else if (!imem_ready) begin
          state_d = WAIT;
        end else if (redir_now) begin
          pc_ld        = 1'b1;
          pc_d         = pend_target_q;
          pend_redir_d = 1'b0;
          state_d      = RUN;
        end else if (stall) begin
          state_d = RUN;
        end else if (is_hlt) begin
          state_d = HALT;
        end else begin
          pc_ld   = 1'b1;
          state_d = RUN;
        end
      end
      HALT: begin
        if (branch_taken) begin
          pc_ld   = 1'b1;
          pc_d    = branch_target;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    req = 1'b0;
    hlt = 1'b0;
    wen = 1'b0;
    vld = 1'b0;
    case (state_q)
      RUN, WAIT: begin
        req = 1'b1;
        if (branch_taken)                  wen = 1'b1;
        else if (!imem_ready || redir_now) wen = ~stall;
        else if (!stall) begin
          wen = 1'b1;
          vld = 1'b1;
        end
      end
      HALT: begin
        hlt = 1'b1;
        wen = branch_taken | ~stall;
      end
      default: ;
    endcase
  end

  // Reset forces the handshake and F/D controls quiet without waiting for a clock.
  assign imem_req        = req & rst;
  assign halted          = hlt & rst;
  assign fd_wen          = wen & rst;
  assign fd_valid        = vld & rst;
  assign imem_addr       = pc_q;
  assign oldPC_out       = pc_q;
  assign newPC_out       = pc_inc;
  assign instruction_out = fd_valid ? imem_rdata : NOP_INSTR;
endmodule
